// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register behind alu_32.
// Captures ALU result and the instruction context in a 2-entry skid buffer
// (main + skid), resolves branches/JAL and pulses a registered redirect to fetch.
// Optional performance counters are built when EX_PERF_CNT_EN is defined.
module ex_mem_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_inst,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cmp,
    input  logic [WIDTH-1:0] in_store_data,
    input  logic             flush_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_inst,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] perf_taken,
    output logic [WIDTH-1:0] perf_stall
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_inst, r_main_pc, r_main_result, r_main_sd;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_inst, r_skid_pc, r_skid_result, r_skid_sd;
    logic             r_in_ready;
    logic             r_redirect_valid;
    logic [WIDTH-1:0] r_redirect_pc;

    logic             w_accept, w_keep, w_pop;
    logic             w_is_branch, w_is_jal, w_taken;
    logic [WIDTH-1:0] w_imm_b, w_imm_j, w_target, w_result;

    // Handshake and decode of the incoming beat
    assign w_accept    = in_valid & r_in_ready;
    // Beats arriving in the redirect cycle are wrong-path; flush kills everything
    assign w_keep      = w_accept & ~r_redirect_valid & ~flush_i;
    assign w_pop       = r_main_valid & out_ready;
    assign w_is_branch = (in_inst[6:0] == OPC_BRANCH);
    assign w_is_jal    = (in_inst[6:0] == OPC_JAL);
    assign w_taken     = (w_is_branch & in_cmp) | w_is_jal;
    assign w_imm_b     = {{(WIDTH-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0};
    assign w_imm_j     = {{(WIDTH-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0};
    assign w_target    = in_pc + (w_is_jal ? w_imm_j : w_imm_b);
    assign w_result    = w_is_jal ? (in_pc + WIDTH'(4)) : in_result;

    // Skid buffer, ready register and redirect pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid     <= 1'b0;
            r_main_inst      <= '0;
            r_main_pc        <= '0;
            r_main_result    <= '0;
            r_main_sd        <= '0;
            r_skid_valid     <= 1'b0;
            r_skid_inst      <= '0;
            r_skid_pc        <= '0;
            r_skid_result    <= '0;
            r_skid_sd        <= '0;
            r_in_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_keep & w_taken;
            if (w_keep & w_taken) begin
                r_redirect_pc <= w_target;
            end
            if (flush_i) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_pop && r_skid_valid) begin
                // skid full implies in_ready=0, so no new beat competes here
                r_main_valid  <= 1'b1;
                r_main_inst   <= r_skid_inst;
                r_main_pc     <= r_skid_pc;
                r_main_result <= r_skid_result;
                r_main_sd     <= r_skid_sd;
                r_skid_valid  <= 1'b0;
                r_in_ready    <= 1'b1;
            end else if (w_keep && (!r_main_valid || w_pop)) begin
                r_main_valid  <= 1'b1;
                r_main_inst   <= in_inst;
                r_main_pc     <= in_pc;
                r_main_result <= w_result;
                r_main_sd     <= in_store_data;
            end else if (w_keep) begin
                r_skid_valid  <= 1'b1;
                r_skid_inst   <= in_inst;
                r_skid_pc     <= in_pc;
                r_skid_result <= w_result;
                r_skid_sd     <= in_store_data;
                r_in_ready    <= 1'b0;
            end else if (w_pop) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_main_valid;
    assign out_inst       = r_main_inst;
    assign out_pc         = r_main_pc;
    assign out_result     = r_main_result;
    assign out_store_data = r_main_sd;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef EX_PERF_CNT_EN
    logic [WIDTH-1:0] r_perf_taken, r_perf_stall;

    // Taken-branch and MEM back-pressure counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_taken <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_keep & w_taken) begin
                r_perf_taken <= r_perf_taken + WIDTH'(1);
            end
            if (r_main_valid & ~out_ready) begin
                r_perf_stall <= r_perf_stall + WIDTH'(1);
            end
        end
    end

    assign perf_taken = r_perf_taken;
    assign perf_stall = r_perf_stall;
`else
    assign perf_taken = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: queue-based reference model plus directed vectors.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0, in_pc = '0, in_result = '0, in_store_data = '0;
    logic        in_cmp = 1'b0;
    logic        flush_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst, out_pc, out_result, out_store_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc, perf_taken, perf_stall;

    ex_mem_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_result(in_result),
        .in_cmp(in_cmp), .in_store_data(in_store_data),
        .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_result(out_result),
        .out_store_data(out_store_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .perf_taken(perf_taken), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] sd;
    } beat_t;

    beat_t       q[$];
    logic        m_redir = 1'b0;
    logic [31:0] m_rpc = '0;
    logic [31:0] m_taken = '0;
    logic [31:0] m_stall = '0;

    function automatic logic is_taken(input logic [31:0] i, input logic c);
        return (i[6:0] == 7'b1100011 && c) || (i[6:0] == 7'b1101111);
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] i, input logic [31:0] pc);
        logic [12:0] b;
        logic [20:0] j;
        int          off;
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        if (i[6:0] == 7'b1101111) off = int'($signed(j));
        else                      off = int'($signed(b));
        return pc + 32'(off);
    endfunction

    // Model update: a 2-deep FIFO whose ready means "fewer than two held"
    always @(posedge clk) begin
        int    sz;
        logic  keep;
        beat_t b;
        if (rst) begin
            q.delete();
            m_redir = 1'b0;
            m_taken = '0;
            m_stall = '0;
        end else begin
            sz   = q.size();
            keep = in_valid && (sz < 2) && !m_redir && !flush_i;
            if (sz > 0 && !out_ready) m_stall++;
            if (flush_i) begin
                q.delete();
                m_redir = 1'b0;
            end else begin
                if (sz > 0 && out_ready) void'(q.pop_front());
                if (keep) begin
                    b.inst   = in_inst;
                    b.pc     = in_pc;
                    b.result = (in_inst[6:0] == 7'b1101111) ? in_pc + 32'd4 : in_result;
                    b.sd     = in_store_data;
                    q.push_back(b);
                end
                m_redir = keep && is_taken(in_inst, in_cmp);
                if (m_redir) begin
                    m_rpc = target_of(in_inst, in_pc);
                    m_taken++;
                end
            end
        end
    end

    // Compare process: DUT against model on every cycle once checking is enabled
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("out_inst", out_inst, q[0].inst);
                chk("out_pc", out_pc, q[0].pc);
                chk("out_result", out_result, q[0].result);
                chk("out_store_data", out_store_data, q[0].sd);
            end
            chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
            if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef EX_PERF_CNT_EN
            chk("perf_taken", perf_taken, m_taken);
            chk("perf_stall", perf_stall, m_stall);
`else
            chk("perf_taken", perf_taken, 32'd0);
            chk("perf_stall", perf_stall, 32'd0);
`endif
        end
    end

    // Record beats leaving toward MEM while enabled
    logic        rec_en = 1'b0;
    logic [31:0] popped[$];
    always @(posedge clk) begin
        if (rec_en && out_valid && out_ready) popped.push_back(out_pc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Present a beat and hold it until the handshake completes (bounded)
    task automatic put(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] res, input logic cmp, input logic [31:0] sd);
        logic rdy;
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        in_result = res; in_cmp = cmp; in_store_data = sd;
        for (int k = 0; k < 20; k++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_chk++; n_fail++;
        $display("FAIL handshake_timeout: got in_ready=0 for 20 cycles, expected acceptance");
    endtask

    localparam logic [31:0] ADD = 32'h0000_0033;
    localparam logic [31:0] BEQ = 32'h0000_0463;
    localparam logic [31:0] JAL = 32'h0100_006F;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst = 1'b1;
        step(); step();
        chk_en = 1'b1;
        rst = 1'b0;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);

        // 1: plain ALU beat
        put(ADD, 32'h100, 32'h0113_FFFE, 1'b0, 32'h1111_0000);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_result", out_result, 32'h0113_FFFE);
        chk("t1_redirect", 32'(redirect_valid), 32'd0);
        step();

        // 2: BEQ taken then not taken
        put(BEQ, 32'h200, 32'h0, 1'b1, 32'h2222_0000);
        chk("t2_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("t2_redirect_pc", redirect_pc, 32'h208);
        step();
        chk("t2_redirect_pulse", 32'(redirect_valid), 32'd0);
        put(BEQ, 32'h200, 32'h0, 1'b0, 32'h2222_0001);
        chk("t2_nt_redirect", 32'(redirect_valid), 32'd0);
        chk("t2_nt_out_pc", out_pc, 32'h200);
        step();

        // 3: JAL, then a wrong-path beat in the redirect cycle
        put(JAL, 32'h300, 32'hDEAD_BEEF, 1'b0, 32'h3333_0000);
        chk("t3_out_result", out_result, 32'h304);
        chk("t3_redirect_pc", redirect_pc, 32'h310);
        put(ADD, 32'h400, 32'h4444_4444, 1'b0, 32'h4444_0000);
        chk("t3_squash_out_valid", 32'(out_valid), 32'd0);
        chk("t3_squash_redirect", 32'(redirect_valid), 32'd0);
        step();

        // 4: back-pressure with three back-to-back beats
        out_ready = 1'b0;
        rec_en    = 1'b1;
        put(ADD, 32'h500, 32'hA, 1'b0, 32'hA0);
        put(ADD, 32'h504, 32'hB, 1'b0, 32'hB0);
        chk("t4_in_ready_full", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_inst = ADD; in_pc = 32'h508; in_result = 32'hC;
        in_cmp = 1'b0; in_store_data = 32'hC0;
        step();
        chk("t4_hold_out_pc", out_pc, 32'h500);
        chk("t4_hold_out_result", out_result, 32'hA);
        out_ready = 1'b1;
        put(ADD, 32'h508, 32'hC, 1'b0, 32'hC0);
        step(); step(); step();
        rec_en = 1'b0;
        chk("t4_pop_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("t4_order0", popped[0], 32'h500);
            chk("t4_order1", popped[1], 32'h504);
            chk("t4_order2", popped[2], 32'h508);
        end

        // 5: flush with main and skid full, then flush colliding with an accept
        out_ready = 1'b0;
        put(ADD, 32'h600, 32'h6, 1'b0, 32'h60);
        put(ADD, 32'h604, 32'h7, 1'b0, 32'h70);
        in_valid = 1'b1; in_inst = JAL; in_pc = 32'h700; flush_i = 1'b1;
        step();
        in_valid = 1'b0; flush_i = 1'b0;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_redirect", 32'(redirect_valid), 32'd0);
        in_valid = 1'b1; in_inst = JAL; in_pc = 32'h704; flush_i = 1'b1;
        step();
        in_valid = 1'b0; flush_i = 1'b0;
        chk("t5b_out_valid", 32'(out_valid), 32'd0);
        chk("t5b_redirect", 32'(redirect_valid), 32'd0);
        out_ready = 1'b1;
        step();

        // 6: counters from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_taken", perf_taken, 32'd0);
        chk("t6_rst_stall", perf_stall, 32'd0);
        put(BEQ, 32'h200, 32'h0, 1'b1, 32'h0);
        step();
        put(JAL, 32'h300, 32'h0, 1'b0, 32'h0);
        step();
        out_ready = 1'b0;
        put(ADD, 32'h800, 32'h8, 1'b0, 32'h80);
        step(); step(); step();
`ifdef EX_PERF_CNT_EN
        chk("t6_perf_taken", perf_taken, 32'd2);
        chk("t6_perf_stall", perf_stall, 32'd3);
`else
        chk("t6_perf_taken_off", perf_taken, 32'd0);
        chk("t6_perf_stall_off", perf_stall, 32'd0);
`endif
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_clear_taken", perf_taken, 32'd0);
        chk("t6_clear_stall", perf_stall, 32'd0);
        chk("t6_clear_out_valid", 32'(out_valid), 32'd0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of alu_32.
- Captures the ALU result and cmp_out together with the instruction, PC and store data.
- Resolves conditional branches and JAL, and issues a registered redirect to fetch.
- Holds accepted instructions in a 2-entry skid buffer so a stalled memory stage never drops an ALU result.

Parameters:
- WIDTH, 32, datapath width (result, pc, store data, instruction).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX beat valid.
- in_ready  out  1  stage can accept a beat.
- in_inst  in  WIDTH  instruction word in EX (same encoding driven to alu_32 inst).
- in_pc  in  WIDTH  PC of in_inst.
- in_result  in  WIDTH  alu_32 out.
- in_cmp  in  1  alu_32 cmp_out (branch condition per funct3).
- in_store_data  in  WIDTH  rs2 value, for stores.
- flush_i  in  1  squash from a later stage.
- out_valid  out  1  MEM beat valid.
- out_ready  in  1  MEM accepts beat.
- out_inst, out_pc, out_result, out_store_data  out  WIDTH each  registered MEM-side copies.
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  WIDTH  branch/JAL target.
- perf_taken, perf_stall  out  WIDTH each  counters (see Optional Feature).

Behaviour:
- Reset: all valids 0; out_* = 0; redirect_valid = 0; redirect_pc = 0; counters = 0; in_ready = 1 in the cycle after reset.
- Buffer: main entry drives out_*; skid entry holds overflow.
  - in_ready = ~skid_valid (registered, no combinational path from out_ready).
  - accept = in_valid & in_ready.
- On accept:
  - If main is empty, or main is emptying this cycle (out_ready) with skid empty, the beat loads main.
  - Otherwise the beat loads skid.
- When main empties via out_ready and skid is full, skid moves to main the same edge and skid clears.
- out_valid/out_* stay stable while out_valid & ~out_ready.
- Result capture:
  - opcode 7'b1101111 (JAL): stored result = in_pc + 4, modulo 2^WIDTH.
  - All other opcodes: stored result = in_result.
- Branch decode, evaluated on accept:
  - opcode 7'b1100011 with in_cmp = 1, or opcode 7'b1101111 -> taken.
  - B-imm = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - J-imm = sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - Target = in_pc + imm, wrapping modulo 2^WIDTH.
- Redirect:
  - A taken beat accepted at edge N sets redirect_valid = 1 and redirect_pc = target for the cycle after edge N.
  - redirect_valid clears at edge N+1.
  - Redirect is independent of out_ready stalls.
- Wrong-path squash: any beat accepted while redirect_valid = 1 is discarded. It is not stored, raises no redirect, and in_ready is still honoured for the handshake.
- Not-taken branch: no redirect; the beat passes to MEM normally.
- flush_i = 1:
  - Clears main and skid valids at the next edge.
  - Discards any same-cycle accept; no redirect is generated from it.
  - Flush has priority over accept and over a pending redirect, which is cleared.
- rst mid-operation overrides flush_i and all handshakes.

Optional Feature:
- Macro EX_PERF_CNT_EN.
- Defined:
  - perf_taken increments by 1 on each taken-branch or JAL accept that is not squashed.
  - perf_stall increments each cycle out_valid & ~out_ready.
  - Both counters wrap at 2^WIDTH and clear only on rst.
- Undefined: no counter registers are built; perf_taken and perf_stall are tied to 0.

Test Plan:
1. ADD beat, pc=0x100, result=0x0113FFFE, out_ready=1 -> out_valid next cycle, out_result=0x0113FFFE, no redirect.
2. BEQ inst=0x00000063 with bit-pattern imm=+8 (inst=0x00000463), pc=0x200, in_cmp=1 -> redirect_valid 1 cycle, redirect_pc=0x208. Same with in_cmp=0 -> no redirect, beat passes.
3. JAL inst=0x0100006F (imm=+16), pc=0x300 -> out_result=0x304, redirect_pc=0x310. A beat presented in the redirect cycle -> dropped, never appears on out_*.
4. out_ready=0 with three back-to-back beats A,B,C -> A in main, B in skid, in_ready=0, C held. Then out_ready=1 -> A, B, C emerge in order, no loss or duplication.
5. Main and skid full, flush_i=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no redirect.
6. EX_PERF_CNT_EN defined: 2 taken branches + 3 stall cycles -> perf_taken=2, perf_stall=3. rst asserted -> both 0 next cycle.
